vadd_req_seq: RTL

VADD_REQ_SEQ -- requirements
Module: vadd_req_seq

---
 rtl/vadd_req_seq.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/vadd_req_seq.sv
// vadd_req_seq: splits a vector add/min/max command into per-beat issue
// bundles for the downstream datapath, then waits out the pipeline latency
// before pulsing done.
module vadd_req_seq #(
    parameter int unsigned REQ_DATA_WIDTH    = 64,
    parameter int unsigned REQ_BYTE_EN_WIDTH = REQ_DATA_WIDTH / 8,
    parameter int unsigned REQ_ADDR_WIDTH    = 32,
    parameter int unsigned OPSEL_WIDTH       = 9,
    parameter int unsigned VL_WIDTH          = 11,
    parameter int unsigned PIPE_LATENCY      = 6,
    parameter bit          ENABLE_64_BIT     = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [VL_WIDTH-1:0]          cmd_vl,
    input  logic [1:0]                   cmd_sew,
    input  logic [OPSEL_WIDTH-1:0]       cmd_opSel,
    input  logic [REQ_ADDR_WIDTH-1:0]    cmd_addr,
    input  logic                         cmd_carry,
    input  logic                         cmd_mask,
    input  logic                         cmd_avg,
    input  logic                         opnd_valid,
    output logic                         opnd_ready,
    input  logic [REQ_DATA_WIDTH-1:0]    opnd_vec0,
    input  logic [REQ_DATA_WIDTH-1:0]    opnd_vec1,
    input  logic [REQ_BYTE_EN_WIDTH-1:0] opnd_v0,
    output logic                         out_valid,
    output logic [REQ_DATA_WIDTH-1:0]    out_vec0,
    output logic [REQ_DATA_WIDTH-1:0]    out_vec1,
    output logic [1:0]                   out_sew,
    output logic [OPSEL_WIDTH-1:0]       out_opSel,
    output logic                         out_carry,
    output logic                         out_mask,
    output logic                         out_avg,
    output logic [REQ_ADDR_WIDTH-1:0]    out_addr,
    output logic [REQ_BYTE_EN_WIDTH-1:0] out_be,
    output logic [5:0]                   out_start_idx,
    output logic                         out_req_start,
    output logic                         out_req_end,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    // Element index needs one extra bit: it can overshoot vl by up to one beat.
    localparam int unsigned CW  = VL_WIDTH + 1;
    localparam int unsigned DCW = $clog2(PIPE_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    state_t                     state, state_nxt;
    logic [VL_WIDTH-1:0]        vl_q;
    logic [1:0]                 sew_q;
    logic [OPSEL_WIDTH-1:0]     opsel_q;
    logic [REQ_ADDR_WIDTH-1:0]  addr_q;
    logic                       carry_q, mask_q, avg_q, err_q;
    logic [VL_WIDTH-1:0]        rem_q;
    logic [CW-1:0]              idx_q;
    logic [VL_WIDTH-1:0]        beat_q;
    logic [DCW-1:0]             cnt_q;

    logic                       cmd_fire, beat_fire, cmd_short, cmd_bad_sew;
    logic [CW-1:0]              epb, rem_ext, take, rem_bytes;
    logic                       full_beat, last_beat, mask_prod;
    logic [REQ_BYTE_EN_WIDTH-1:0] be_nxt;
    logic [REQ_ADDR_WIDTH-1:0]  addr_nxt;

    assign cmd_fire    = cmd_valid && (state == IDLE);
    assign beat_fire   = opnd_valid && (state == ISSUE);
    assign cmd_bad_sew = (cmd_sew == 2'd3) && (ENABLE_64_BIT == 1'b0);
    assign cmd_short   = (cmd_vl == '0) || cmd_bad_sew;

    assign epb       = CW'(REQ_BYTE_EN_WIDTH) >> sew_q;
    assign rem_ext   = {1'b0, rem_q};
    assign full_beat = rem_ext >= epb;
    assign last_beat = rem_ext <= epb;
    assign take      = last_beat ? rem_ext : epb;
    assign rem_bytes = rem_ext << sew_q;
    assign mask_prod = opsel_q[8] || (carry_q && !mask_q);
    assign addr_nxt  = mask_prod ? addr_q + REQ_ADDR_WIDTH'(idx_q >> 6)
                                 : addr_q + REQ_ADDR_WIDTH'(beat_q);

    // Byte enables for the beat being issued.
    always_comb begin
        be_nxt = '0;
        if (carry_q && mask_q) begin
            be_nxt = opnd_v0;
        end else if (full_beat) begin
            be_nxt = '1;
        end else begin
            for (int unsigned i = 0; i < REQ_BYTE_EN_WIDTH; i++) begin
                be_nxt[i] = CW'(i) < rem_bytes;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        opnd_ready = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_nxt = cmd_short ? FIN : ISSUE;
            end
            ISSUE: begin
                opnd_ready = 1'b1;
                if (opnd_valid && last_beat) state_nxt = DRAIN;
            end
            // Counter reaches 0 on the same edge that enters FIN, so done lands
            // exactly PIPE_LATENCY cycles after the last handshake cycle.
            DRAIN: begin
                if (cnt_q <= DCW'(1)) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                err       = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch, beat bookkeeping and drain counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            vl_q    <= '0;
            sew_q   <= '0;
            opsel_q <= '0;
            addr_q  <= '0;
            carry_q <= 1'b0;
            mask_q  <= 1'b0;
            avg_q   <= 1'b0;
            err_q   <= 1'b0;
            rem_q   <= '0;
            idx_q   <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (cmd_fire) begin
                vl_q    <= cmd_vl;
                sew_q   <= cmd_sew;
                opsel_q <= cmd_opSel;
                addr_q  <= cmd_addr;
                carry_q <= cmd_carry;
                mask_q  <= cmd_mask;
                avg_q   <= cmd_avg;
                err_q   <= cmd_bad_sew;
                rem_q   <= cmd_vl;
                idx_q   <= '0;
                beat_q  <= '0;
            end
            if (beat_fire) begin
                rem_q  <= rem_q - take[VL_WIDTH-1:0];
                idx_q  <= idx_q + epb;
                beat_q <= beat_q + 1'b1;
            end
            if (beat_fire && last_beat)  cnt_q <= DCW'(PIPE_LATENCY - 1);
            else if (state == DRAIN)     cnt_q <= cnt_q - 1'b1;
        end
    end

    // Registered issue bundle; all fields forced to zero when nothing issues.
    always_ff @(posedge clk) begin
        if (rst || !beat_fire) begin
            out_valid     <= 1'b0;
            out_vec0      <= '0;
            out_vec1      <= '0;
            out_sew       <= '0;
            out_opSel     <= '0;
            out_carry     <= 1'b0;
            out_mask      <= 1'b0;
            out_avg       <= 1'b0;
            out_addr      <= '0;
            out_be        <= '0;
            out_start_idx <= '0;
            out_req_start <= 1'b0;
            out_req_end   <= 1'b0;
        end else begin
            out_valid     <= 1'b1;
            out_vec0      <= opnd_vec0;
            out_vec1      <= opnd_vec1;
            out_sew       <= sew_q;
            out_opSel     <= opsel_q;
            out_carry     <= carry_q;
            out_mask      <= mask_q;
            out_avg       <= avg_q;
            out_addr      <= addr_nxt;
            out_be        <= be_nxt;
            out_start_idx <= mask_prod ? idx_q[5:0] : 6'd0;
            out_req_start <= beat_q == '0;
            out_req_end   <= last_beat;
        end
    end

endmodule
